// File: rtl/ahb_apb_sys.sv
`default_nettype none
// ============================================================================
// ahb_apb_sys : AHB-Lite slave bridging to an internal APB bus, four register-file peripherals
// Revision    : 1.0
// ============================================================================
module ahb_apb_sys #(
  parameter int PSLV_BITS = 2,
  parameter int PSEL_LSB  = 24
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA
);

  localparam logic [31:0] ID_VALUE = 32'h4150_4253;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_next;

  logic        accept;
  logic        load;
  logic        psel;
  logic        penable;
  logic        pready;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        wr_en;
  logic [PSLV_BITS-1:0] sel;
  logic [1:0]  off;

  logic [31:0] word_regs [4];
  logic [15:0] half_regs [4];
  logic [7:0]  byte_regs [4];

  // Fields the bridge never looks at; reduced here so nothing dangles.
  logic unused_bits;
  assign unused_bits = ^{HSIZE, HTRANS[0], paddr};

  assign accept = HSEL & HTRANS[1] & HREADY;
  assign pready = 1'b1;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    HREADYOUT  = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
          load       = 1'b1;
        end
      end
      SETUP: begin
        psel       = 1'b1;
        HREADYOUT  = 1'b0;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        HREADYOUT = pready;
        if (pready) begin
          if (accept) begin
            state_next = SETUP;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_next;
  end

  // Address/control captured on accept; write data follows one cycle later (AHB data phase).
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
    end else begin
      if (load) begin
        paddr  <= HADDR;
        pwrite <= HWRITE;
      end
      if (state == SETUP) pwdata <= HWDATA;
    end
  end

  assign sel   = paddr[PSEL_LSB +: PSLV_BITS];
  assign off   = paddr[3:2];
  assign wr_en = psel & penable & pwrite & pready;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < 4; i++) begin
        word_regs[i] <= '0;
        half_regs[i] <= '0;
        byte_regs[i] <= '0;
      end
    end else if (wr_en) begin
      case (sel)
        PSLV_BITS'(0): word_regs[off] <= pwdata;
        PSLV_BITS'(1): half_regs[off] <= pwdata[15:0];
        PSLV_BITS'(2): byte_regs[off] <= pwdata[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    prdata = '0;
    case (sel)
      PSLV_BITS'(0): prdata = word_regs[off];
      PSLV_BITS'(1): prdata = {16'h0000, half_regs[off]};
      PSLV_BITS'(2): prdata = {24'h000000, byte_regs[off]};
      PSLV_BITS'(3): prdata = (off == 2'd0) ? ID_VALUE : 32'h0;
      default:       prdata = '0;
    endcase
  end

  assign HRDATA = (psel & penable) ? prdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_apb_sys.sv
`default_nettype none
// ============================================================================
// tb_ahb_apb_sys : directed table, corner sequences and random traffic against a register model
// Revision       : 1.0
// ============================================================================
module tb_ahb_apb_sys;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_apb_sys dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one 4-entry bank per peripheral, width enforced by a mask.
  logic [31:0] mem [4][4];

  function automatic logic [31:0] bank_mask(input int s);
    case (s)
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_FFFF;
      2:       return 32'h0000_00FF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    int s = int'(a[25:24]);
    int o = int'(a[3:2]);
    if (s == 3) return (o == 0) ? 32'h4150_4253 : 32'h0;
    return mem[s][o];
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d);
    int s = int'(a[25:24]);
    int o = int'(a[3:2]);
    if (s != 3) mem[s][o] = d & bank_mask(s);
  endtask

  task automatic mdl_reset();
    for (int s = 0; s < 4; s++)
      for (int o = 0; o < 4; o++)
        mem[s][o] = 32'h0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One non-pipelined transfer; entered and left at a negedge with the bridge idle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output int waits);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = 3'b010;
    @(negedge HCLK);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWDATA = wr ? wd : $urandom;
    waits  = 0;
    while (HREADYOUT !== 1'b1 && waits < 16) begin
      waits++;
      @(negedge HCLK);
    end
    rd = HRDATA;
    @(negedge HCLK);
  endtask

  task automatic do_xfer(input string name, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd);
    logic [31:0] rd;
    int          waits;
    logic [31:0] exp;
    exp = mdl_read(addr);
    xfer(wr, addr, wd, rd, waits);
    check({name, "_waits"}, 32'(waits), 32'd1);
    if (wr) mdl_write(addr, wd);
    else    check({name, "_rdata"}, rd, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    int          waits;

    vecs[0]  = '{1'b0, 32'h4000_0000, 32'h0,         32'h0};
    vecs[1]  = '{1'b1, 32'h4000_0000, 32'h000D_EEEE, 32'h0};
    vecs[2]  = '{1'b0, 32'h4000_0000, 32'h0,         32'h000D_EEEE};
    vecs[3]  = '{1'b1, 32'h4200_0004, 32'h000D_DDDD, 32'h0};
    vecs[4]  = '{1'b0, 32'h4200_0004, 32'h0,         32'h0000_00DD};
    vecs[5]  = '{1'b0, 32'h4000_0004, 32'h0,         32'h0};
    vecs[6]  = '{1'b0, 32'h4200_0000, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, 32'h4100_0008, 32'hCAFE_BABE, 32'h0};
    vecs[8]  = '{1'b0, 32'h4100_0008, 32'h0,         32'h0000_BABE};
    vecs[9]  = '{1'b0, 32'h4300_0000, 32'h0,         32'h4150_4253};
    vecs[10] = '{1'b1, 32'h4300_0000, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 32'h4300_0000, 32'h0,         32'h4150_4253};
    vecs[12] = '{1'b0, 32'h4300_0004, 32'h0,         32'h0};

    HRESET = 1'b1;
    HSEL   = 1'b0;
    HADDR  = 32'h0;
    HTRANS = 2'b00;
    HSIZE  = 3'b010;
    HWRITE = 1'b0;
    HWDATA = 32'h0;
    mdl_reset();

    repeat (10) @(negedge HCLK);
    check("reset_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("reset_hrdata", HRDATA, 32'h0);
    HRESET = 1'b0;
    @(negedge HCLK);
    check("idle_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("idle_hrdata", HRDATA, 32'h0);

    for (int i = 0; i < 13; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, waits);
      check($sformatf("vec%0d_waits", i), 32'(waits), 32'd1);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      else             mdl_write(vecs[i].addr, vecs[i].data);
    end

    // Pipelined write then read: read address is presented while the write is stalled.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_0008; HWRITE = 1'b1;
    @(negedge HCLK);
    check("pipe_wr_setup_wait", {31'h0, HREADYOUT}, 32'h0);
    HWDATA = 32'h1234_5678;
    HWRITE = 1'b0;
    @(negedge HCLK);
    check("pipe_wr_access_ready", {31'h0, HREADYOUT}, 32'h1);
    @(negedge HCLK);
    check("pipe_rd_setup_wait", {31'h0, HREADYOUT}, 32'h0);
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    check("pipe_rd_access_ready", {31'h0, HREADYOUT}, 32'h1);
    check("pipe_rd_data", HRDATA, 32'h1234_5678);
    mdl_write(32'h4000_0008, 32'h1234_5678);
    @(negedge HCLK);

    // Reset during the SETUP cycle of a write aborts it.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_000C; HWRITE = 1'b1;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF;
    HRESET = 1'b1;
    @(negedge HCLK);
    check("abort_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    HRESET = 1'b0;
    mdl_reset();
    @(negedge HCLK);
    do_xfer("abort_target", 1'b0, 32'h4000_000C, 32'h0);
    do_xfer("abort_clears", 1'b0, 32'h4000_0008, 32'h0);

    // Random traffic with non-accepted bus cycles interleaved.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       begin HSEL = 1'b0; HTRANS = 2'b10; end
          1:       begin HSEL = 1'b1; HTRANS = 2'b00; end
          default: begin HSEL = 1'b1; HTRANS = 2'b01; end
        endcase
        HADDR  = 32'h4000_0000;
        HWRITE = 1'b1;
        HWDATA = $urandom;
        @(negedge HCLK);
        check("noaccept_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        check("noaccept_hrdata", HRDATA, 32'h0);
        HSEL = 1'b0; HTRANS = 2'b00;
      end
      a = {6'b010000, 2'($urandom_range(0, 3)), 20'($urandom), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3))};
      d = $urandom;
      do_xfer("rand", 1'($urandom_range(0, 1)), a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_apb_sys.md
Name: ahb_apb_sys

Overview:
- Self-contained AHB-Lite slave subsystem: an AHB-to-APB bridge plus an internal APB bus with four register-file peripherals.
- Sits on the system AHB as one slave (HSEL-selected) in the 0x4000_0000–0x43FF_FFFF window.
- Converts each AHB NONSEQ/SEQ transfer into one APB SETUP/ACCESS transaction, inserting wait states via HREADYOUT.

Parameters:
- PSLV_BITS, 2, width of the peripheral-select field; four APB slaves.
- PSEL_LSB, 24, lowest HADDR bit of the peripheral-select field (HADDR[25:24]).

Ports:
- HCLK  in  1  system clock; all logic is rising-edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  AHB slave select.
- HADDR  in  32  AHB address.
- HTRANS  in  2  AHB transfer type; bit 1 set = NONSEQ/SEQ (active).
- HSIZE  in  3  transfer size; accepted but ignored, all accesses are full-word.
- HWRITE  in  1  1 = write, 0 = read.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; an address phase is taken only when HREADY=1.
- HREADYOUT  out  1  slave ready; 0 inserts a wait state.
- HRDATA  out  32  read data.

Behaviour:
- Reset (HRESET=1 at a clock edge) puts the FSM in IDLE and drives HREADYOUT=1, HRDATA=0. All peripheral registers clear to 0.
- Transfer accept: accept = HSEL & HTRANS[1] & HREADY. On accept, register HADDR and HWRITE.
- FSM states are IDLE, SETUP, ACCESS:
  - IDLE -> SETUP on accept.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> IDLE when PREADY=1 and there is no new accept; ACCESS -> SETUP when PREADY=1 and a new accept occurs in the same cycle.
  - ACCESS stays in ACCESS while PREADY=0.
- Internal APB signals:
  - PADDR = latched address. PWRITE = latched HWRITE. PWDATA = HWDATA, sampled in SETUP.
  - PSEL is asserted in SETUP and ACCESS. PENABLE is asserted only in ACCESS.
- HREADYOUT is 0 in SETUP. In ACCESS it equals PREADY. Otherwise it is 1.
- Latency: all internal slaves have PREADY=1, so each transfer has exactly one wait state (a two-cycle data phase).
- HRDATA equals the selected slave's PRDATA in ACCESS and is 0 otherwise. It is registered nowhere else.
- Peripheral decode uses PADDR[25:24]. Register offset is PADDR[3:2]. PADDR[1:0] and other bits are ignored.
  - Slave 0 (0x4000_0000): four 32-bit R/W registers. A write stores all 32 bits.
  - Slave 1 (0x4100_0000): four 16-bit R/W registers. A write stores PWDATA[15:0]; reads are zero-extended.
  - Slave 2 (0x4200_0000): four 8-bit R/W registers. A write stores PWDATA[7:0]; reads are zero-extended.
  - Slave 3 (0x4300_0000): read-only. Offset 0 returns 32'h4150_4253 ("APBS"); other offsets return 0. Writes are ignored.
- A slave register is updated at the rising edge that ends ACCESS, when PSEL & PENABLE & PWRITE & PREADY are all 1.
- IDLE/BUSY transfers (HTRANS[1]=0), or HSEL=0, cause no APB activity and keep HREADYOUT=1.
- Reset asserted mid-transfer aborts it: the FSM goes to IDLE, no register write occurs, and HREADYOUT=1 on the next cycle.
- There is no error response. Unmapped offsets read 0.

Test Plan:
- Reset, then idle: HRESET high for 10 cycles, then low -> HREADYOUT=1, HRDATA=0; reading 0x4000_0000 returns 0.
- Word register: write 0x4000_0000 <- 32'h000D_EEEE, then read 0x4000_0000 -> 32'h000D_EEEE; HREADYOUT low for exactly one cycle per transfer.
- Byte register: write 0x4200_0004 <- 32'h000D_DDDD, then read 0x4200_0004 -> 32'h0000_00DD.
- Isolation: after the two writes above, read 0x4000_0004 -> 0 and 0x4200_0000 -> 0. Write 0x4100_0008 <- 32'hCAFE_BABE, then read it -> 32'h0000_BABE.
- Read-only/ID: read 0x4300_0000 -> 32'h4150_4253. Write 0x4300_0000 <- 0, then read again -> still 32'h4150_4253.
- Back-to-back and reset abort:
  - Pipelined NONSEQ write then read to 0x4000_0008 -> the read returns the written value.
  - Assert HRESET during the SETUP cycle of a write -> the target register stays 0.
